// File: rtl/dds_wave_shaper.sv
// Phase-to-amplitude stage: phase offset, sine/square/triangle/saw shaping, amplitude scaling.
// Latency 3 cycles from i_in_valid to o_out_valid, one sample per cycle, bubbles pass through.
// No backpressure: every accepted sample is produced; mode/amp changes apply only at a period wrap.
//
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   i_in_valid                 i_phase_in / i_phase_offset valid this cycle
//   i_phase_in, i_phase_offset phase word and additive offset (mod 2^PHASE_W)
//   i_cfg_load                 one-cycle strobe capturing i_cfg_mode / i_cfg_amp into pending
//   i_cfg_mode, i_cfg_amp      0 sine, 1 square, 2 triangle, 3 sawtooth; unsigned amplitude
//   o_cfg_pending              staged configuration not yet applied
//   o_out_valid, o_out_sample  scaled unsigned sample (S_W+AMP_W bits), holds while invalid
//   o_out_wrap                 sample starts a new waveform period
module dds_wave_shaper #(
    parameter int PHASE_W = 10,
    parameter int S_W     = 9,
    parameter int AMP_W   = 9
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   i_in_valid,
    input  logic [PHASE_W-1:0]     i_phase_in,
    input  logic [PHASE_W-1:0]     i_phase_offset,
    input  logic                   i_cfg_load,
    input  logic [1:0]             i_cfg_mode,
    input  logic [AMP_W-1:0]       i_cfg_amp,
    output logic                   o_cfg_pending,
    output logic                   o_out_valid,
    output logic [S_W+AMP_W-1:0]   o_out_sample,
    output logic                   o_out_wrap
);

    localparam int K_W = PHASE_W - 2;       // quarter-wave table address width
    localparam int QN  = 2 ** K_W;          // quarter-wave table depth
    localparam int Q_W = S_W - 1;           // table entries never exceed 2^(S_W-1)-1
    localparam int MID = 2 ** (S_W - 1);    // offset-binary mid-scale
    localparam int O_W = S_W + AMP_W;

    typedef enum logic [1:0] {
        MODE_SINE   = 2'd0,
        MODE_SQUARE = 2'd1,
        MODE_TRI    = 2'd2,
        MODE_SAW    = 2'd3
    } mode_t;

    // Table entry k holds round((2^(S_W-1)-1) * sin(2*pi*(k+0.5)/2^PHASE_W)).
    // The half-step offset keeps the mirrored quadrants symmetric and the sine
    // output away from zero. Evaluated with a Taylor series so the table is
    // fully determined at elaboration for any parameter set.
    function automatic int quarter_sin(input int k);
        real x;
        real term;
        real acc;
        x    = 2.0 * 3.14159265358979323846 * (real'(k) + 0.5) / real'(2 ** PHASE_W);
        term = x;
        acc  = x;
        for (int n = 1; n < 12; n++) begin
            term = -term * x * x / real'((2 * n) * (2 * n + 1));
            acc  = acc + term;
        end
        return $rtoi(acc * real'(MID - 1) + 0.5);
    endfunction

    logic [Q_W-1:0] w_rom [QN];

    genvar g;
    generate
        for (g = 0; g < QN; g++) begin : g_rom
            assign w_rom[g] = Q_W'(quarter_sin(g));
        end
    endgenerate

    // ------------------------------------------------------------------
    // Stage 1: effective phase, wrap detect, config staging/apply
    // ------------------------------------------------------------------
    logic               r_seen;
    logic [PHASE_W-1:0] r_prev_eff;
    logic               r_pend;
    mode_t              r_pend_mode;
    logic [AMP_W-1:0]   r_pend_amp;
    mode_t              r_act_mode;
    logic [AMP_W-1:0]   r_act_amp;

    logic               r_s1_vld;
    logic [PHASE_W-1:0] r_s1_eff;
    logic               r_s1_wrap;
    mode_t              r_s1_mode;
    logic [AMP_W-1:0]   r_s1_amp;

    logic [PHASE_W-1:0] w_eff;
    logic               w_wrap;
    logic               w_apply;
    mode_t              w_sel_mode;
    logic [AMP_W-1:0]   w_sel_amp;

    assign w_eff   = i_phase_in + i_phase_offset;
    // First sample after reset always opens a period; otherwise a backwards step marks the wrap.
    assign w_wrap  = !r_seen || (w_eff < r_prev_eff);
    // Apply uses the pending value held at the start of this cycle, even if a new load lands now.
    assign w_apply = i_in_valid && w_wrap && r_pend;
    assign w_sel_mode = w_apply ? r_pend_mode : r_act_mode;
    assign w_sel_amp  = w_apply ? r_pend_amp  : r_act_amp;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_seen      <= 1'b0;
            r_prev_eff  <= '0;
            r_pend      <= 1'b0;
            r_pend_mode <= MODE_SINE;
            r_pend_amp  <= '0;
            r_act_mode  <= MODE_SINE;
            r_act_amp   <= '0;
            r_s1_vld    <= 1'b0;
            r_s1_eff    <= '0;
            r_s1_wrap   <= 1'b0;
            r_s1_mode   <= MODE_SINE;
            r_s1_amp    <= '0;
        end else begin
            r_s1_vld <= i_in_valid;
            if (i_in_valid) begin
                r_s1_eff   <= w_eff;
                r_s1_wrap  <= w_wrap;
                r_s1_mode  <= w_sel_mode;
                r_s1_amp   <= w_sel_amp;
                r_prev_eff <= w_eff;
                r_seen     <= 1'b1;
            end
            if (w_apply) begin
                r_act_mode <= r_pend_mode;
                r_act_amp  <= r_pend_amp;
            end
            // A load coinciding with an apply re-arms pending with the new values.
            if (i_cfg_load) begin
                r_pend_mode <= mode_t'(i_cfg_mode);
                r_pend_amp  <= i_cfg_amp;
                r_pend      <= 1'b1;
            end else if (w_apply) begin
                r_pend <= 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Stage 2: waveform shaping
    // ------------------------------------------------------------------
    logic [K_W-1:0] w_k;
    logic [K_W-1:0] w_addr;
    logic [Q_W-1:0] w_q;
    logic           w_msb;
    logic [S_W-1:0] w_tri;
    logic [S_W-1:0] w_shape;

    assign w_msb  = r_s1_eff[PHASE_W-1];
    assign w_k    = r_s1_eff[K_W-1:0];
    // Quadrants 1 and 3 read the table mirrored.
    assign w_addr = r_s1_eff[PHASE_W-2] ? ~w_k : w_k;
    assign w_q    = w_rom[w_addr];
    assign w_tri  = r_s1_eff[PHASE_W-2 -: S_W];

    always_comb begin
        w_shape = '0;
        case (r_s1_mode)
            MODE_SINE:   w_shape = w_msb ? (S_W'(MID) - {1'b0, w_q}) : (S_W'(MID) + {1'b0, w_q});
            MODE_SQUARE: w_shape = w_msb ? '0 : '1;
            MODE_TRI:    w_shape = w_msb ? ~w_tri : w_tri;
            MODE_SAW:    w_shape = r_s1_eff[PHASE_W-1 -: S_W];
            default:     w_shape = '0;
        endcase
    end

    logic             r_s2_vld;
    logic [S_W-1:0]   r_s2_sample;
    logic             r_s2_wrap;
    logic [AMP_W-1:0] r_s2_amp;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_s2_vld    <= 1'b0;
            r_s2_sample <= '0;
            r_s2_wrap   <= 1'b0;
            r_s2_amp    <= '0;
        end else begin
            r_s2_vld <= r_s1_vld;
            if (r_s1_vld) begin
                r_s2_sample <= w_shape;
                r_s2_wrap   <= r_s1_wrap;
                r_s2_amp    <= r_s1_amp;
            end
        end
    end

    // ------------------------------------------------------------------
    // Stage 3: full-precision amplitude multiply; outputs hold while idle
    // ------------------------------------------------------------------
    logic           r_out_vld;
    logic [O_W-1:0] r_out_sample;
    logic           r_out_wrap;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_out_vld    <= 1'b0;
            r_out_sample <= '0;
            r_out_wrap   <= 1'b0;
        end else begin
            r_out_vld <= r_s2_vld;
            if (r_s2_vld) begin
                r_out_sample <= {{AMP_W{1'b0}}, r_s2_sample} * {{S_W{1'b0}}, r_s2_amp};
                r_out_wrap   <= r_s2_wrap;
            end
        end
    end

    assign o_cfg_pending = r_pend;
    assign o_out_valid   = r_out_vld;
    assign o_out_sample  = r_out_sample;
    assign o_out_wrap    = r_out_wrap;

endmodule

// File: tb/tb_dds_wave_shaper.sv
// Bench for dds_wave_shaper: directed phase/config vectors against a per-cycle reference model.
// Reference model tracks period wraps and staged config; output sine is computed from sin() directly.
// Literal expectations on the observed output stream pin the model's own arithmetic.
module tb_dds_wave_shaper;

    localparam int PW  = 10;
    localparam int SW  = 9;
    localparam int AW  = 9;
    localparam int OW  = SW + AW;
    localparam int PMOD = 2 ** PW;
    localparam int MID  = 2 ** (SW - 1);

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          in_valid = 1'b0;
    logic [PW-1:0] phase_in = '0;
    logic [PW-1:0] phase_offset = '0;
    logic          cfg_load = 1'b0;
    logic [1:0]    cfg_mode = '0;
    logic [AW-1:0] cfg_amp = '0;
    logic          o_cfg_pending;
    logic          o_out_valid;
    logic [OW-1:0] o_out_sample;
    logic          o_out_wrap;

    dds_wave_shaper #(.PHASE_W(PW), .S_W(SW), .AMP_W(AW)) dut (
        .clk            (clk),
        .reset          (reset),
        .i_in_valid     (in_valid),
        .i_phase_in     (phase_in),
        .i_phase_offset (phase_offset),
        .i_cfg_load     (cfg_load),
        .i_cfg_mode     (cfg_mode),
        .i_cfg_amp      (cfg_amp),
        .o_cfg_pending  (o_cfg_pending),
        .o_out_valid    (o_out_valid),
        .o_out_sample   (o_out_sample),
        .o_out_wrap     (o_out_wrap)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    int m_seen, m_prev, m_pend, m_pmode, m_pamp, m_amode, m_aamp;
    int p_v[2], p_s[2], p_w[2];
    int e_vld, e_smp, e_wrap;
    bit started = 1'b0;

    function automatic int shape(input int mode, input int eff);
        real s;
        real a;
        int  m;
        case (mode)
            0: begin
                s = $sin(2.0 * 3.14159265358979323846 * (real'(eff) + 0.5) / real'(PMOD));
                a = (s < 0.0) ? -s : s;
                m = $rtoi(a * real'(MID - 1) + 0.5);
                return (s >= 0.0) ? MID + m : MID - m;
            end
            1: return (eff < PMOD / 2) ? (2 ** SW) - 1 : 0;
            2: return (eff < PMOD / 2) ? eff : (PMOD - 1) - eff;
            default: return eff / (2 ** (PW - SW));
        endcase
    endfunction

    task automatic model_step();
        int eff;
        int wrap;
        int apply;
        apply = 0;
        if (reset) begin
            m_seen = 0; m_prev = 0; m_pend = 0; m_pmode = 0; m_pamp = 0;
            m_amode = 0; m_aamp = 0;
            for (int i = 0; i < 2; i++) begin p_v[i] = 0; p_s[i] = 0; p_w[i] = 0; end
            e_vld = 0; e_smp = 0; e_wrap = 0;
        end else begin
            e_vld = p_v[1];
            if (p_v[1] != 0) begin e_smp = p_s[1]; e_wrap = p_w[1]; end
            p_v[1] = p_v[0]; p_s[1] = p_s[0]; p_w[1] = p_w[0];
            p_v[0] = int'(in_valid);
            if (in_valid) begin
                eff  = (int'(phase_in) + int'(phase_offset)) % PMOD;
                wrap = (m_seen == 0 || eff < m_prev) ? 1 : 0;
                apply = (wrap != 0 && m_pend != 0) ? 1 : 0;
                if (apply != 0) begin m_amode = m_pmode; m_aamp = m_pamp; end
                p_s[0] = shape(m_amode, eff) * m_aamp;
                p_w[0] = wrap;
                m_prev = eff;
                m_seen = 1;
            end
            if (cfg_load) begin
                m_pmode = int'(cfg_mode); m_pamp = int'(cfg_amp); m_pend = 1;
            end else if (apply != 0) begin
                m_pend = 0;
            end
        end
    endtask

    initial begin
        forever begin
            @(posedge clk);
            model_step();
            started = 1'b1;
        end
    end

    // ---------------- per-cycle compare + output capture ----------------
    int obs_s[$];
    int obs_w[$];

    initial begin
        forever begin
            @(negedge clk);
            if (started) begin
                check("out_valid",   32'(o_out_valid),   32'(e_vld));
                check("out_sample",  32'(o_out_sample),  32'(e_smp));
                check("out_wrap",    32'(o_out_wrap),    32'(e_wrap));
                check("cfg_pending", 32'(o_cfg_pending), 32'(m_pend));
                if (o_out_valid === 1'b1) begin
                    obs_s.push_back(int'(o_out_sample));
                    obs_w.push_back(int'(o_out_wrap));
                end
            end
        end
    end

    // Pops the next produced sample and compares it with a hand-computed literal.
    // exp_s < 0 checks only the wrap flag.
    task automatic pin(input string name, input int exp_s, input int exp_w);
        int waited;
        int s;
        int w;
        waited = 0;
        while (obs_s.size() == 0 && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        if (obs_s.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL %s: no output sample within 20 cycles", name);
        end else begin
            s = obs_s.pop_front();
            w = obs_w.pop_front();
            if (exp_s >= 0) check(name, 32'(s), 32'(exp_s));
            check({name, "_wrap"}, 32'(w), 32'(exp_w));
        end
    endtask

    task automatic step(input bit v, input int ph, input int off, input bit ld, input int md, input int am);
        in_valid     = v;
        phase_in     = PW'(ph);
        phase_offset = PW'(off);
        cfg_load     = ld;
        cfg_mode     = 2'(md);
        cfg_amp      = AW'(am);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        cfg_load = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 0, 0, 1'b0, 0, 0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        check("rst_out_valid",   32'(o_out_valid),   32'd0);
        check("rst_out_sample",  32'(o_out_sample),  32'd0);
        check("rst_out_wrap",    32'(o_out_wrap),    32'd0);
        check("rst_cfg_pending", 32'(o_cfg_pending), 32'd0);

        // Sine, amp 1
        step(1'b0, 0, 0, 1'b1, 0, 1);
        check("load_sets_pending", 32'(o_cfg_pending), 32'd1);
        step(1'b1, 0,   0, 1'b0, 0, 0);
        step(1'b1, 256, 0, 1'b0, 0, 0);
        step(1'b1, 768, 0, 1'b0, 0, 0);
        idle(4);
        pin("sine_p0",   257, 1);
        pin("sine_p256", 511, 0);
        pin("sine_p768", 1,   0);

        // Square amp 2, then sawtooth via offset wrap to eff 0
        step(1'b0, 0, 0, 1'b1, 1, 2);
        step(1'b1, 100, 0, 1'b0, 0, 0);
        step(1'b1, 600, 0, 1'b0, 0, 0);
        step(1'b0, 0, 0, 1'b1, 3, 2);
        step(1'b1, 1023, 1, 1'b0, 0, 0);
        step(1'b1, 900,  0, 1'b0, 0, 0);
        idle(4);
        pin("square_p100", 1022, 1);
        pin("square_p600", 0,    0);
        pin("saw_eff0",    0,    1);
        pin("saw_p900",    900,  0);

        // Triangle amp 1
        step(1'b0, 0, 0, 1'b1, 2, 1);
        step(1'b1, 511,  0, 1'b0, 0, 0);
        step(1'b1, 512,  0, 1'b0, 0, 0);
        step(1'b1, 1023, 0, 1'b0, 0, 0);
        idle(4);
        pin("tri_p511",  511, 1);
        pin("tri_p512",  511, 0);
        pin("tri_p1023", 0,   0);

        // Staged amplitude change waits for the period boundary
        step(1'b0, 0, 0, 1'b1, 0, 1);
        step(1'b1, 100, 0, 1'b0, 0, 0);
        step(1'b1, 200, 0, 1'b1, 0, 3);
        step(1'b1, 300, 0, 1'b0, 0, 0);
        check("staged_pending_held", 32'(o_cfg_pending), 32'd1);
        step(1'b1, 10, 0, 1'b0, 0, 0);
        check("staged_pending_cleared", 32'(o_cfg_pending), 32'd0);
        idle(4);
        pin("staged_p100", 403, 1);
        pin("staged_p200", 496, 0);
        pin("staged_p300", 502, 0);
        pin("staged_p10",  816, 1);

        // Load coinciding with an apply
        step(1'b0, 0, 0, 1'b1, 0, 2);
        step(1'b1, 500, 0, 1'b0, 0, 0);
        step(1'b1, 5,   0, 1'b0, 0, 0);
        step(1'b0, 0, 0, 1'b1, 0, 3);
        step(1'b1, 700, 0, 1'b0, 0, 0);
        step(1'b1, 50,  0, 1'b1, 0, 5);
        check("simul_pending_stays", 32'(o_cfg_pending), 32'd1);
        step(1'b1, 60, 0, 1'b0, 0, 0);
        step(1'b1, 40, 0, 1'b0, 0, 0);
        check("simul_pending_cleared", 32'(o_cfg_pending), 32'd0);
        idle(4);
        pin("simul_p500", 822,  0);
        pin("simul_p5",   530,  1);
        pin("simul_p700", 46,   0);
        pin("simul_p50",  1002, 1);
        pin("simul_p60",  -1,   0);
        pin("simul_p40",  1595, 1);

        // Bubbles
        step(1'b1, 100, 0, 1'b0, 0, 0);
        step(1'b0, 0,   0, 1'b0, 0, 0);
        step(1'b1, 200, 0, 1'b0, 0, 0);
        idle(4);
        pin("bubble_p100", 2015, 0);
        pin("bubble_p200", 2480, 0);

        // Reset with samples in flight
        step(1'b1, 300, 0, 1'b0, 0, 0);
        step(1'b1, 400, 0, 1'b0, 0, 0);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        idle(6);
        check("midrst_no_output",  32'(obs_s.size()), 32'd0);
        check("midrst_out_sample", 32'(o_out_sample),  32'd0);
        check("midrst_out_wrap",   32'(o_out_wrap),    32'd0);
        step(1'b1, 300, 0, 1'b0, 0, 0);
        idle(4);
        pin("postrst_first", 0, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/dds_wave_shaper.md
Name: dds_wave_shaper

Overview:
Parametrised, pipelined phase-to-amplitude stage for the DDS chain. It sits between the phase accumulator and the DAC/output register. It adds a phase offset, then generates one of four waveforms: sine from a quarter-wave LUT, square, triangle or sawtooth. The result is scaled by a registered amplitude. Amplitude and mode changes are staged and take effect only at a waveform-period boundary, so there are no mid-cycle glitches.

Parameters:
PHASE_W, 10, phase word width; must be >= S_W+1
S_W, 9, unscaled sample width, offset-binary (mid-scale = 2^(S_W-1))
AMP_W, 9, amplitude word width, unsigned

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
in_valid  in  1  phase_in/phase_offset valid this cycle; bubbles allowed, no backpressure
phase_in  in  PHASE_W  phase from accumulator
phase_offset  in  PHASE_W  phase offset, sampled with in_valid
cfg_load  in  1  one-cycle strobe: capture cfg_mode/cfg_amp into pending
cfg_mode  in  2  0 sine, 1 square, 2 triangle, 3 sawtooth
cfg_amp  in  AMP_W  amplitude multiplier
cfg_pending  out  1  staged config not yet applied
out_valid  out  1  out_sample valid
out_sample  out  S_W+AMP_W  scaled sample, unsigned
out_wrap  out  1  qualifies out_valid; this sample starts a new period (config applied here)

Behaviour:
- Clock and reset: one clock, clk. reset is synchronous, active-high.
- Reset values: out_valid=0, out_sample=0, out_wrap=0, cfg_pending=0. Internal state: active mode=sine, active amp=0, pending cleared, pipeline valids cleared, seen flag cleared.
- Reset mid-operation: in-flight samples are dropped. out_valid=0 from the cycle after reset is sampled.
- Effective phase: eff = (phase_in + phase_offset) mod 2^PHASE_W.
- Wrap detect (valid samples only): wrap = !seen | (eff < prev_eff). On each valid sample, prev_eff <= eff and seen <= 1.
- Config apply: on a valid sample with wrap=1 and pending set, active mode/amp <= pending values and pending clears.
  - The applied values are used for that same sample.
  - Apply uses pending as of the start of the cycle.
- Config staging:
  - cfg_load overwrites pending (mode, amp) and sets cfg_pending.
  - A second load before apply overwrites the first.
  - cfg_load coinciding with an apply: the old pending is applied, the new values become pending, and cfg_pending stays 1.
- Pipeline, 3 stages, latency 3 cycles from in_valid to out_valid, throughput 1/cycle:
  - S1: register eff, wrap, selected mode/amp.
  - S2: waveform shaping.
  - S3: multiply.
- Sine: quarter-wave table q[k], k = 0..2^(PHASE_W-2)-1, with q[k] = round((2^(S_W-1)-1) * sin(2π(k+0.5)/2^PHASE_W)).
  - Quadrant = eff[MSB:MSB-1]; k = eff[PHASE_W-3:0].
  - Q0: addr k; Q1: addr ~k; Q2: addr k; Q3: addr ~k.
  - Sample = 2^(S_W-1) + q for Q0/Q1, 2^(S_W-1) - q for Q2/Q3.
  - Range 1..2^S_W-1; never 0.
- Square: eff MSB=0 → 2^S_W-1, else 0.
- Triangle: t = eff[PHASE_W-2 -: S_W]. Sample = t when MSB=0, else ~t.
- Sawtooth: sample = eff[PHASE_W-1 -: S_W].
- Scaling: out_sample = sample * amp, full-precision unsigned, no truncation or saturation. amp=0 → out_sample=0.
- out_sample and out_wrap hold their last value while out_valid=0.

Test Plan:
- Reset then cfg_load(mode 0, amp 1); then in_valid phases 0, 256, 768 with offset 0 → out_sample 257, 511, 1 on cycles 3, 4, 5 after the first input; out_wrap=1 on the first only.
- Mode 1 with amp 2: phases 100, 600 → 1022, 0. Mode 3 with phase 1023, offset 1 → eff 0, out 0 with wrap=1.
- Mode 2 with amp 1: phases 511, 512, 1023 → 511, 511, 0.
- Staged apply:
  - Setup: active amp 1, sine; phases 100, 200, 300 streaming; cfg_load amp 3 issued after phase 100.
  - cfg_pending=1 through phase 300, whose output uses amp 1.
  - Phase 10 (wrap) → out_wrap=1, sample scaled ×3 (e.g. q[10]-based value ×3), cfg_pending=0 one cycle after that sample is accepted.
- Simultaneous: cfg_load amp 5 on the same cycle as a wrapping sample with pending amp 3 → that sample uses amp 3; cfg_pending stays 1; the next wrap applies amp 5.
- Bubbles and reset:
  - in_valid toggling 1,0,1 → out_valid 1,0,1 delayed by 3 cycles.
  - Assert reset with 2 samples in flight → no out_valid afterwards; all outputs 0; first post-reset sample has out_wrap=1 and amp 0 → out 0.
